divide_seq_ctrl: RTL and testbench

DIVIDE_SEQ_CTRL -- requirements
Module: divide_seq_ctrl

---
 rtl/div_pkg.sv | 31 +++
 rtl/divide_seq_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_divide_seq_ctrl.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential signed divide controller.
package div_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_FIX,
    S_DONE
  } state_t;

  localparam int unsigned STAGE_LAT = 4;
  localparam int unsigned NPASS     = 32;
  localparam int unsigned DW        = 32;
  localparam int unsigned CW        = 5;
  localparam int unsigned PW        = 6;

  localparam logic [DW-1:0] INT_MIN = 32'h8000_0000;
  localparam logic [DW-1:0] INT_MAX = 32'h7FFF_FFFF;

  // Unsigned magnitude of a two's-complement value; INT_MIN maps to itself.
  function automatic logic [DW-1:0] abs_mag(input logic [DW-1:0] x);
    return x[DW-1] ? DW'((~x) + DW'(1)) : x;
  endfunction

  // Conditional two's-complement negate with 32-bit wrap.
  function automatic logic [DW-1:0] neg_if(input logic s, input logic [DW-1:0] x);
    return s ? DW'((~x) + DW'(1)) : x;
  endfunction

endpackage

// File: rtl/divide_seq_ctrl.sv
// Sequencer for a signed 32-bit divide built from an external one-bit step.
module divide_seq_ctrl #(
  parameter int unsigned STAGE_LAT = div_pkg::STAGE_LAT,
  parameter int unsigned NPASS     = div_pkg::NPASS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_by_zero,
  output logic [31:0] st_A,
  output logic [31:0] st_B,
  output logic [31:0] st_R,
  output logic [31:0] st_Q,
  output logic [4:0]  st_count,
  output logic        st_v,
  input  logic [31:0] st_A_next,
  input  logic [31:0] st_B_next,
  input  logic [31:0] st_R_next,
  input  logic [31:0] st_Q_next,
  input  logic [4:0]  st_count_in,
  input  logic        st_vout,
  output logic        stage_err
);

  import div_pkg::*;

  localparam int unsigned LAT_W = (STAGE_LAT > 1) ? $clog2(STAGE_LAT) : 1;

  // Termination is driven by the internal pass counter; the returned index is not needed.
  logic unused_count_in;
  assign unused_count_in = ^st_count_in;

  state_t          state, state_nxt;
  logic [LAT_W-1:0] lat_cnt, lat_nxt;
  logic [PW-1:0]   pass_cnt, pass_nxt, pass_inc;
  logic [DW-1:0]   r_q, r_nxt, q_q, q_nxt;
  logic            sign_q, sign_q_nxt, sign_r, sign_r_nxt, dz_q, dz_nxt;

  logic            in_ready_nxt, out_valid_nxt, div_by_zero_nxt, st_v_nxt, stage_err_nxt;
  logic [DW-1:0]   quotient_nxt, remainder_nxt;
  logic [DW-1:0]   st_A_nxt, st_B_nxt, st_R_nxt, st_Q_nxt;
  logic [CW-1:0]   st_count_nxt;

  // Next-state and next-output decode.
  always_comb begin
    state_nxt       = state;
    lat_nxt         = lat_cnt;
    pass_nxt        = pass_cnt;
    pass_inc        = PW'(pass_cnt + PW'(1));
    r_nxt           = r_q;
    q_nxt           = q_q;
    sign_q_nxt      = sign_q;
    sign_r_nxt      = sign_r;
    dz_nxt          = dz_q;
    in_ready_nxt    = in_ready;
    out_valid_nxt   = out_valid;
    quotient_nxt    = quotient;
    remainder_nxt   = remainder;
    div_by_zero_nxt = div_by_zero;
    st_A_nxt        = st_A;
    st_B_nxt        = st_B;
    st_R_nxt        = st_R;
    st_Q_nxt        = st_Q;
    st_count_nxt    = st_count;
    st_v_nxt        = 1'b0;
    stage_err_nxt   = stage_err;

    case (state)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          in_ready_nxt = 1'b0;
          sign_q_nxt   = dividend[DW-1] ^ divisor[DW-1];
          sign_r_nxt   = dividend[DW-1];
          dz_nxt       = 1'b0;
          if (divisor == '0) begin
            // Saturated quotient, remainder passes through; FIX applies no sign.
            state_nxt  = S_FIX;
            q_nxt      = dividend[DW-1] ? INT_MIN : INT_MAX;
            r_nxt      = dividend;
            sign_q_nxt = 1'b0;
            sign_r_nxt = 1'b0;
            dz_nxt     = 1'b1;
          end else if (divisor == INT_MIN) begin
            // Only INT_MIN itself reaches a magnitude of 2^31.
            state_nxt  = S_FIX;
            q_nxt      = (dividend == INT_MIN) ? DW'(1) : '0;
            r_nxt      = (dividend == INT_MIN) ? '0 : dividend;
            sign_q_nxt = 1'b0;
            sign_r_nxt = 1'b0;
          end else begin
            state_nxt    = S_ISSUE;
            pass_nxt     = '0;
            st_A_nxt     = abs_mag(dividend);
            st_B_nxt     = abs_mag(divisor);
            st_R_nxt     = '0;
            st_Q_nxt     = '0;
            st_count_nxt = '0;
            st_v_nxt     = 1'b1;
          end
        end
      end

      S_ISSUE: begin
        state_nxt = S_WAIT;
        lat_nxt   = '0;
      end

      S_WAIT: begin
        if (lat_cnt == LAT_W'(STAGE_LAT - 1)) begin
          r_nxt    = st_R_next;
          q_nxt    = st_Q_next;
          pass_nxt = pass_inc;
          if (!st_vout) begin
            stage_err_nxt = 1'b1;
          end
          if (pass_inc == PW'(NPASS)) begin
            state_nxt = S_FIX;
          end else begin
            state_nxt    = S_ISSUE;
            st_A_nxt     = st_A_next;
            st_B_nxt     = st_B_next;
            st_R_nxt     = st_R_next;
            st_Q_nxt     = st_Q_next;
            st_count_nxt = CW'(pass_inc);
            st_v_nxt     = 1'b1;
          end
        end else begin
          lat_nxt = LAT_W'(lat_cnt + LAT_W'(1));
        end
      end

      S_FIX: begin
        state_nxt       = S_DONE;
        quotient_nxt    = neg_if(sign_q, q_q);
        remainder_nxt   = neg_if(sign_r, r_q);
        div_by_zero_nxt = dz_q;
        out_valid_nxt   = 1'b1;
      end

      S_DONE: begin
        if (out_ready) begin
          state_nxt     = S_IDLE;
          out_valid_nxt = 1'b0;
          in_ready_nxt  = 1'b1;
        end
      end

      default: begin
        state_nxt     = S_IDLE;
        out_valid_nxt = 1'b0;
        in_ready_nxt  = 1'b1;
      end
    endcase
  end

  // State, working and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      lat_cnt     <= '0;
      pass_cnt    <= '0;
      r_q         <= '0;
      q_q         <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      dz_q        <= 1'b0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      st_A        <= '0;
      st_B        <= '0;
      st_R        <= '0;
      st_Q        <= '0;
      st_count    <= '0;
      st_v        <= 1'b0;
      stage_err   <= 1'b0;
    end else begin
      state       <= state_nxt;
      lat_cnt     <= lat_nxt;
      pass_cnt    <= pass_nxt;
      r_q         <= r_nxt;
      q_q         <= q_nxt;
      sign_q      <= sign_q_nxt;
      sign_r      <= sign_r_nxt;
      dz_q        <= dz_nxt;
      in_ready    <= in_ready_nxt;
      out_valid   <= out_valid_nxt;
      quotient    <= quotient_nxt;
      remainder   <= remainder_nxt;
      div_by_zero <= div_by_zero_nxt;
      st_A        <= st_A_nxt;
      st_B        <= st_B_nxt;
      st_R        <= st_R_nxt;
      st_Q        <= st_Q_nxt;
      st_count    <= st_count_nxt;
      st_v        <= st_v_nxt;
      stage_err   <= stage_err_nxt;
    end
  end

endmodule

// File: tb/tb_divide_seq_ctrl.sv
// Bench for divide_seq_ctrl: external step model, result/timing model, directed ops.
module tb_divide_seq_ctrl;

  localparam int L  = 4;
  localparam int NP = 32;
  localparam logic [31:0] IMIN = 32'h8000_0000;
  localparam logic [31:0] IMAX = 32'h7FFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] dividend = '0, divisor = '0;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] quotient, remainder;
  logic        div_by_zero;
  logic [31:0] st_A, st_B, st_R, st_Q;
  logic [4:0]  st_count;
  logic        st_v;
  logic [31:0] st_A_next, st_B_next, st_R_next, st_Q_next;
  logic [4:0]  st_count_in;
  logic        st_vout;
  logic        stage_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  divide_seq_ctrl #(.STAGE_LAT(L), .NPASS(NP)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero),
    .st_A(st_A), .st_B(st_B), .st_R(st_R), .st_Q(st_Q),
    .st_count(st_count), .st_v(st_v),
    .st_A_next(st_A_next), .st_B_next(st_B_next), .st_R_next(st_R_next), .st_Q_next(st_Q_next),
    .st_count_in(st_count_in), .st_vout(st_vout),
    .stage_err(stage_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // External one-bit restoring divide step with a fixed L-cycle pipeline.
  typedef struct packed {
    logic        v;
    logic [4:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [31:0] q;
  } stg_t;

  function automatic stg_t step(input stg_t s);
    stg_t o;
    logic [32:0] rr;
    rr  = {s.r, s.a[31]};
    o   = s;
    o.a = {s.a[30:0], 1'b0};
    if (rr >= {1'b0, s.b}) begin
      o.r = 32'(rr - {1'b0, s.b});
      o.q = {s.q[30:0], 1'b1};
    end else begin
      o.r = rr[31:0];
      o.q = {s.q[30:0], 1'b0};
    end
    return o;
  endfunction

  stg_t pipe [L];
  logic drop_vout = 1'b0;

  always @(posedge clk) begin
    pipe[0] <= step('{v: st_v, c: st_count, a: st_A, b: st_B, r: st_R, q: st_Q});
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end

  assign st_A_next   = pipe[L-1].a;
  assign st_B_next   = pipe[L-1].b;
  assign st_R_next   = pipe[L-1].r;
  assign st_Q_next   = pipe[L-1].q;
  assign st_count_in = pipe[L-1].c;
  assign st_vout     = pipe[L-1].v & ~drop_vout;

  // Behavioural model: results from plain signed arithmetic, timing from cycle arithmetic.
  logic        m_busy = 1'b0, m_special = 1'b0, m_dz = 1'b0, exp_serr = 1'b0;
  int          m_cyc = 0, m_done = 0;
  logic [31:0] m_q = '0, m_r = '0, m_aabs = '0, m_babs = '0;

  task automatic model_load(input logic [31:0] dd, input logic [31:0] dv);
    int a, b;
    a = dd;
    b = dv;
    m_dz      = 1'b0;
    m_special = 1'b1;
    if (dv == 32'd0) begin
      m_q  = (a >= 0) ? IMAX : IMIN;
      m_r  = dd;
      m_dz = 1'b1;
    end else if (dv == IMIN) begin
      m_q = (dd == IMIN) ? 32'd1 : 32'd0;
      m_r = (dd == IMIN) ? 32'd0 : dd;
    end else begin
      m_special = 1'b0;
      m_q = a / b;
      m_r = a % b;
    end
    m_aabs = (a < 0) ? -a : a;
    m_babs = (b < 0) ? -b : b;
    m_done = m_special ? 2 : 2 + NP * (L + 1);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy   = 1'b0;
      m_cyc    = 0;
      exp_serr = 1'b0;
    end else if (!m_busy) begin
      if (in_valid) begin
        model_load(dividend, divisor);
        m_busy = 1'b1;
        m_cyc  = 1;
      end
    end else if (m_cyc >= m_done && out_ready) begin
      m_busy = 1'b0;
    end else begin
      if (drop_vout && !m_special && m_cyc >= L + 1 && (m_cyc % (L + 1)) == 0 && m_cyc <= m_done - 2)
        exp_serr = 1'b1;
      m_cyc++;
    end
  end

  // Per-cycle comparison against the model.
  int  stv_seen = 0, ov_seen = 0;
  logic exp_ov, exp_stv;
  always @(negedge clk) begin
    if (rst_n) begin
      exp_ov  = m_busy && m_cyc >= m_done;
      exp_stv = m_busy && !m_special && m_cyc < m_done - 1 && ((m_cyc - 1) % (L + 1)) == 0;
      if (st_v) stv_seen++;
      if (out_valid) ov_seen++;
      chk("in_ready", {31'd0, in_ready}, {31'd0, !m_busy});
      chk("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
      chk("st_v", {31'd0, st_v}, {31'd0, exp_stv});
      chk("stage_err", {31'd0, stage_err}, {31'd0, exp_serr});
      if (exp_stv) begin
        chk("st_count", {27'd0, st_count}, 32'((m_cyc - 1) / (L + 1)) & 32'h1F);
        if (m_cyc == 1) begin
          chk("st_A pass0", st_A, m_aabs);
          chk("st_B pass0", st_B, m_babs);
          chk("st_R pass0", st_R, 32'd0);
          chk("st_Q pass0", st_Q, 32'd0);
        end
      end
      if (exp_ov) begin
        chk("quotient", quotient, m_q);
        chk("remainder", remainder, m_r);
        chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, m_dz});
      end
    end
  end

  // One operation with literal expectations; hold>0 stalls out_ready and pokes in_valid.
  task automatic run_op(input string name, input logic [31:0] dd, input logic [31:0] dv,
                        input logic [31:0] eq, input logic [31:0] er, input logic edz,
                        input int elat, input int hold);
    int cyc;
    logic [31:0] q0, r0;
    @(posedge clk); #1;
    in_valid = 1'b1; dividend = dd; divisor = dv; stv_seen = 0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 1;
    while (cyc < 400) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk); #1;
      cyc++;
    end
    chk({name, " latency"}, 32'(cyc), 32'(elat));
    chk({name, " quotient"}, quotient, eq);
    chk({name, " remainder"}, remainder, er);
    chk({name, " div_by_zero"}, {31'd0, div_by_zero}, {31'd0, edz});
    chk({name, " st_v count"}, 32'(stv_seen), (elat == 2) ? 32'd0 : 32'(NP));
    q0 = quotient;
    r0 = remainder;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      in_valid = (i < hold - 2); dividend = 32'd77; divisor = 32'd5;
    end
    if (hold > 0) begin
      @(negedge clk);
      chk({name, " held quotient"}, quotient, q0);
      chk({name, " held remainder"}, remainder, r0);
      chk({name, " held in_ready"}, {31'd0, in_ready}, 32'd0);
      chk({name, " held out_valid"}, {31'd0, out_valid}, 32'd1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk({name, " in_ready after"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset st_v", {31'd0, st_v}, 32'd0);
    chk("reset stage_err", {31'd0, stage_err}, 32'd0);
    chk("reset div_by_zero", {31'd0, div_by_zero}, 32'd0);
    chk("reset quotient", quotient, 32'd0);
    chk("reset remainder", remainder, 32'd0);
    chk("reset st_A", st_A, 32'd0);
    chk("reset st_count", {27'd0, st_count}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready after reset", {31'd0, in_ready}, 32'd1);

    run_op("100/7",        32'd100,            32'd7,             32'd14,          32'd2,           1'b0, 162, 0);
    run_op("-100/7",       -32'sd100,          32'd7,             -32'sd14,        -32'sd2,         1'b0, 162, 0);
    run_op("100/-7",       32'd100,            -32'sd7,           -32'sd14,        32'd2,           1'b0, 162, 0);
    run_op("5/0",          32'd5,              32'd0,             IMAX,            32'd5,           1'b1, 2,   0);
    run_op("-5/0",         -32'sd5,            32'd0,             IMIN,            -32'sd5,         1'b1, 2,   0);
    run_op("min/min",      IMIN,               IMIN,              32'd1,           32'd0,           1'b0, 2,   0);
    run_op("12345/min",    32'd12345,          IMIN,              32'd0,           32'd12345,       1'b0, 2,   0);
    run_op("min/7",        IMIN,               32'd7,             -32'sd306783378, -32'sd2,         1'b0, 162, 0);
    run_op("100/7 stall",  32'd100,            32'd7,             32'd14,          32'd2,           1'b0, 162, 10);
    run_op("9/2 after",    32'd9,              32'd2,             32'd4,           32'd1,           1'b0, 162, 0);

    // Reset in the middle of 1000/3 abandons it.
    @(posedge clk); #1;
    in_valid = 1'b1; dividend = 32'd1000; divisor = 32'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (49) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    ov_seen = 0;
    @(negedge clk);
    chk("in_ready after mid reset", {31'd0, in_ready}, 32'd1);
    repeat (200) @(posedge clk);
    #1;
    chk("out_valid after abandoned op", 32'(ov_seen), 32'd0);
    run_op("9/2 post reset", 32'd9, 32'd2, 32'd4, 32'd1, 1'b0, 162, 0);

    // Missing step returns raise the sticky error but data still flows.
    drop_vout = 1'b1;
    run_op("100/7 no vout", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 162, 0);
    drop_vout = 1'b0;
    chk("stage_err sticky", {31'd0, stage_err}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
